// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite animation controller:
//   - state_t        : controller states
//   - SPR_*          : 3-bit sprite codes presented on sprite_index
//   - sprite_code()  : state -> sprite code decode
//   - is_saturating(): states whose frame_index stops at the last frame
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [2:0] {
        ST_STAND  = 3'd0,
        ST_PUNCH  = 3'd1,
        ST_JUMP   = 3'd2,
        ST_CROUCH = 3'd3,
        ST_LEFT   = 3'd4,
        ST_RIGHT  = 3'd5,
        ST_DEATH  = 3'd6
    } state_t;

    localparam logic [2:0] SPR_STAND  = 3'b000;
    localparam logic [2:0] SPR_PUNCH  = 3'b001;
    localparam logic [2:0] SPR_JUMP   = 3'b010;
    localparam logic [2:0] SPR_CROUCH = 3'b011;
    localparam logic [2:0] SPR_LEFT   = 3'b100;
    localparam logic [2:0] SPR_RIGHT  = 3'b101;
    localparam logic [2:0] SPR_DEATH  = 3'b110;

    function automatic logic [2:0] sprite_code(input state_t s);
        logic [2:0] code;
        code = SPR_STAND;
        case (s)
            ST_STAND:  code = SPR_STAND;
            ST_PUNCH:  code = SPR_PUNCH;
            ST_JUMP:   code = SPR_JUMP;
            ST_CROUCH: code = SPR_CROUCH;
            ST_LEFT:   code = SPR_LEFT;
            ST_RIGHT:  code = SPR_RIGHT;
            ST_DEATH:  code = SPR_DEATH;
            default:   code = SPR_STAND;
        endcase
        return code;
    endfunction

    // One-shot animations (punch, death) hold their last frame instead of looping.
    function automatic logic is_saturating(input state_t s);
        return (s == ST_PUNCH) || (s == ST_DEATH);
    endfunction

endpackage

// File: rtl/anim_counter.sv
// -----------------------------------------------------------------------------
// anim_counter
// Tick and frame counter for one animation.  Counts ticks 0..TICKS_PER_FRAME-1
// and advances the frame index on wrap; the frame index either loops or holds
// at N_FRAMES-1 depending on i_saturate.
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous active-high reset
//   i_tick        in   advance enable (one video frame)
//   i_clear       in   restart animation at tick 0 / frame 0 (qualified by i_tick)
//   i_saturate    in   1: hold at last frame, 0: wrap to frame 0
//   o_frame_index out  current animation frame
// -----------------------------------------------------------------------------
module anim_counter #(
    parameter int N_FRAMES        = 4,
    parameter int TICKS_PER_FRAME = 8
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        i_tick,
    input  logic                        i_clear,
    input  logic                        i_saturate,
    output logic [$clog2(N_FRAMES)-1:0] o_frame_index
);

    localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int FW = $clog2(N_FRAMES);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_FRAME - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(N_FRAMES - 1);

    logic [TW-1:0] r_tick_cnt;
    logic [FW-1:0] r_frame_index;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_tick_cnt    <= '0;
            r_frame_index <= '0;
        end else if (i_tick) begin
            if (i_clear) begin
                r_tick_cnt    <= '0;
                r_frame_index <= '0;
            end else if (r_tick_cnt == TICK_LAST) begin
                r_tick_cnt <= '0;
                if (r_frame_index == FRAME_LAST)
                    r_frame_index <= i_saturate ? FRAME_LAST : '0;
                else
                    r_frame_index <= r_frame_index + 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    assign o_frame_index = r_frame_index;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_anim_ctrl
// Character animation state machine.  Action requests are evaluated once per
// video frame (frame_tick); sprite code, animation frame and punch hitbox
// enable are registered and update on the edge that ends a tick cycle.
// Ports:
//   Clk, Reset                       clock, synchronous active-high reset
//   frame_tick                       one-cycle pulse per video frame
//   punch/jump/crouch/left/right/death  level action requests
//   sprite_index [2:0]               sprite code of current state
//   frame_index                      current animation frame
//   punch_active                     high while punching
// Build option:
//   SPRITE_DEATH_LATCH_EN  defined -> DEATH is left only through Reset.
// -----------------------------------------------------------------------------
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int N_FRAMES        = 4,
    parameter int TICKS_PER_FRAME = 8,
    parameter int PUNCH_TICKS     = 12
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_tick,
    input  logic                        punch,
    input  logic                        jump,
    input  logic                        crouch,
    input  logic                        left,
    input  logic                        right,
    input  logic                        death,
    output logic [2:0]                  sprite_index,
    output logic [$clog2(N_FRAMES)-1:0] frame_index,
    output logic                        punch_active
);

    localparam int PW = $clog2(PUNCH_TICKS + 1);
    // Loaded on entry; PUNCH exits on the tick that finds the counter at zero,
    // which gives exactly PUNCH_TICKS ticks spent in PUNCH.
    localparam logic [PW-1:0] PUNCH_LOAD = PW'(PUNCH_TICKS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_prev_punch;
    logic [PW-1:0] r_punch_cnt;
    logic [2:0]    r_sprite_index;
    logic          r_punch_active;

    logic w_tick;
    logic w_punch_start;
    logic w_punch_hold;
    logic w_state_change;

    assign w_tick         = frame_tick & ~Reset;
    assign w_punch_start  = punch & ~r_prev_punch;
    assign w_punch_hold   = (r_state == ST_PUNCH) && (r_punch_cnt != '0);
    assign w_state_change = (w_next_state != r_state);

    always_comb begin
        w_next_state = ST_STAND;
        if (death)
            w_next_state = ST_DEATH;
`ifdef SPRITE_DEATH_LATCH_EN
        else if (r_state == ST_DEATH)
            w_next_state = ST_DEATH;
`endif
        else if (w_punch_hold)
            w_next_state = ST_PUNCH;
        // A start seen on the expiry tick of a punch is not a new punch.
        else if (w_punch_start && (r_state != ST_PUNCH))
            w_next_state = ST_PUNCH;
        else if (crouch)
            w_next_state = ST_CROUCH;
        else if (jump)
            w_next_state = ST_JUMP;
        else if (left && !right)
            w_next_state = ST_LEFT;
        else if (right && !left)
            w_next_state = ST_RIGHT;
        else
            w_next_state = ST_STAND;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= ST_STAND;
            r_prev_punch   <= 1'b0;
            r_punch_cnt    <= '0;
            r_sprite_index <= SPR_STAND;
            r_punch_active <= 1'b0;
        end else if (frame_tick) begin
            r_state        <= w_next_state;
            r_prev_punch   <= punch;
            r_sprite_index <= sprite_code(w_next_state);
            r_punch_active <= (w_next_state == ST_PUNCH);
            if (w_next_state != ST_PUNCH)
                r_punch_cnt <= '0;
            else if (r_state != ST_PUNCH)
                r_punch_cnt <= PUNCH_LOAD;
            else
                r_punch_cnt <= r_punch_cnt - 1'b1;  // nonzero here by construction
        end
    end

    anim_counter #(
        .N_FRAMES        (N_FRAMES),
        .TICKS_PER_FRAME (TICKS_PER_FRAME)
    ) u_anim_counter (
        .Clk           (Clk),
        .Reset         (Reset),
        .i_tick        (w_tick),
        .i_clear       (w_state_change),
        .i_saturate    (is_saturating(w_next_state)),
        .o_frame_index (frame_index)
    );

    assign sprite_index = r_sprite_index;
    assign punch_active = r_punch_active;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_anim_ctrl
// Scoreboard bench for sprite_anim_ctrl at default parameters.  Each applied
// cycle pushes its expected outputs, then pops and compares them after the edge.
// -----------------------------------------------------------------------------
module tb_sprite_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       punch = 1'b0, jump = 1'b0, crouch = 1'b0;
    logic       left = 1'b0, right = 1'b0, death = 1'b0;
    logic [2:0] sprite_index;
    logic [1:0] frame_index;
    logic       punch_active;

    localparam logic [5:0] A_NONE   = 6'b000000;
    localparam logic [5:0] A_RIGHT  = 6'b000001;
    localparam logic [5:0] A_LEFT   = 6'b000010;
    localparam logic [5:0] A_JUMP   = 6'b000100;
    localparam logic [5:0] A_CROUCH = 6'b001000;
    localparam logic [5:0] A_PUNCH  = 6'b010000;
    localparam logic [5:0] A_DEATH  = 6'b100000;

    localparam logic [2:0] E_STAND  = 3'b000;
    localparam logic [2:0] E_PUNCH  = 3'b001;
    localparam logic [2:0] E_JUMP   = 3'b010;
    localparam logic [2:0] E_CROUCH = 3'b011;
    localparam logic [2:0] E_LEFT   = 3'b100;
    localparam logic [2:0] E_RIGHT  = 3'b101;
    localparam logic [2:0] E_DEATH  = 3'b110;

    typedef struct {
        string      tag;
        logic [2:0] spr;
        logic [1:0] frm;
        logic       pa;
    } exp_t;

    exp_t sb[$];
    int   n_vectors    = 0;
    int   n_miscompare = 0;

    sprite_anim_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .punch        (punch),
        .jump         (jump),
        .crouch       (crouch),
        .left         (left),
        .right        (right),
        .death        (death),
        .sprite_index (sprite_index),
        .frame_index  (frame_index),
        .punch_active (punch_active)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, push its expectation, then pop and compare after the edge.
    task automatic apply(input string tag, input logic rst, input logic tk,
                         input logic [5:0] act, input logic [2:0] e_spr,
                         input int e_frm, input logic e_pa);
        exp_t e;
        e.tag = tag;
        e.spr = e_spr;
        e.frm = 2'(e_frm);
        e.pa  = e_pa;
        sb.push_back(e);
        Reset      = rst;
        frame_tick = tk;
        {death, punch, crouch, jump, left, right} = act;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        e = sb.pop_front();
        check({e.tag, "/spr"}, 32'(sprite_index), 32'(e.spr));
        check({e.tag, "/frm"}, 32'(frame_index),  32'(e.frm));
        check({e.tag, "/pa"},  32'(punch_active), 32'(e.pa));
        $display("vec %-16s spr=%b frm=%0d pa=%b", e.tag, sprite_index, frame_index, punch_active);
    endtask

    initial begin
        // Reset with ticks and requests present: ticks are ignored.
        apply("rst0", 1'b1, 1'b1, A_RIGHT, E_STAND, 0, 1'b0);
        apply("rst1", 1'b1, 1'b1, A_RIGHT, E_STAND, 0, 1'b0);

        // Walk right: frame advances every 8 ticks, loops after 32.
        apply("right_enter", 1'b0, 1'b1, A_RIGHT, E_RIGHT, 0, 1'b0);
        apply("no_tick_hold", 1'b0, 1'b0, A_LEFT, E_RIGHT, 0, 1'b0);
        for (int k = 1; k <= 32; k++)
            apply($sformatf("right_t%0d", k), 1'b0, 1'b1, A_RIGHT, E_RIGHT, (k / 8) % 4, 1'b0);

        // Single punch pulse: 12 ticks of PUNCH, then STAND.
        apply("punch_enter", 1'b0, 1'b1, A_PUNCH, E_PUNCH, 0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (k < 12)
                apply($sformatf("punch_t%0d", k), 1'b0, 1'b1, A_NONE, E_PUNCH, k / 8, 1'b1);
            else
                apply("punch_expire", 1'b0, 1'b1, A_NONE, E_STAND, 0, 1'b0);
        end

        // Held punch: one PUNCH only, no retrigger.
        apply("hold_enter", 1'b0, 1'b1, A_PUNCH, E_PUNCH, 0, 1'b1);
        for (int k = 1; k <= 29; k++) begin
            if (k < 12)
                apply($sformatf("hold_t%0d", k), 1'b0, 1'b1, A_PUNCH, E_PUNCH, k / 8, 1'b1);
            else
                apply($sformatf("hold_t%0d", k), 1'b0, 1'b1, A_PUNCH, E_STAND, ((k - 12) / 8) % 4, 1'b0);
        end
        apply("hold_release", 1'b0, 1'b1, A_NONE, E_STAND, 2, 1'b0);
        apply("repress", 1'b0, 1'b1, A_PUNCH, E_PUNCH, 0, 1'b1);

        // Death preempts punch on its 5th tick, then saturates at frame 3.
        for (int k = 1; k <= 4; k++)
            apply($sformatf("pre_death_t%0d", k), 1'b0, 1'b1, A_NONE, E_PUNCH, 0, 1'b1);
        apply("death_preempt", 1'b0, 1'b1, A_DEATH, E_DEATH, 0, 1'b0);
        for (int k = 1; k <= 40; k++)
            apply($sformatf("death_t%0d", k), 1'b0, 1'b1, A_DEATH, E_DEATH, (k / 8 > 3) ? 3 : k / 8, 1'b0);
`ifdef SPRITE_DEATH_LATCH_EN
        for (int k = 1; k <= 3; k++)
            apply($sformatf("death_latch%0d", k), 1'b0, 1'b1, A_LEFT, E_DEATH, 3, 1'b0);
`else
        apply("death_release", 1'b0, 1'b1, A_NONE, E_STAND, 0, 1'b0);
`endif
        apply("rst_death", 1'b1, 1'b1, A_DEATH, E_STAND, 0, 1'b0);

        // Priority checks.
        apply("crouch_jump_left", 1'b0, 1'b1, A_CROUCH | A_JUMP | A_LEFT, E_CROUCH, 0, 1'b0);
        apply("left_right", 1'b0, 1'b1, A_LEFT | A_RIGHT, E_STAND, 0, 1'b0);
        apply("left_only", 1'b0, 1'b1, A_LEFT, E_LEFT, 0, 1'b0);
        apply("jump_left", 1'b0, 1'b1, A_JUMP | A_LEFT, E_JUMP, 0, 1'b0);

        // Jump to frame 2, then reset mid-animation.
        for (int k = 1; k <= 16; k++)
            apply($sformatf("jump_t%0d", k), 1'b0, 1'b1, A_JUMP, E_JUMP, k / 8, 1'b0);
        apply("rst_mid_jump", 1'b1, 1'b1, A_JUMP, E_STAND, 0, 1'b0);
        apply("after_rst", 1'b0, 1'b1, A_NONE, E_STAND, 0, 1'b0);
        apply("punch_over_jump", 1'b0, 1'b1, A_PUNCH | A_JUMP, E_PUNCH, 0, 1'b1);
        apply("death_over_all", 1'b0, 1'b1, A_DEATH | A_PUNCH | A_CROUCH, E_DEATH, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule
